// File: rtl/perceptron_pkg.sv
// Shared types for the perceptron training slice: feature width, sample record,
// trainer FSM states and the default epoch limit.
package perceptron_pkg;

    localparam int unsigned FEAT_W             = 8;
    localparam int unsigned SAMPLE_W           = 3 * FEAT_W + 1;
    localparam logic [7:0]  DEFAULT_MAX_EPOCHS = 8'd50;

    // Field order matches the host word {desired, x3, x2, x1}.
    typedef struct packed {
        logic              desired;
        logic [FEAT_W-1:0] x3;
        logic [FEAT_W-1:0] x2;
        logic [FEAT_W-1:0] x1;
    } sample_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESENT,
        ST_EPOCH_END,
        ST_FINISH
    } trainer_state_t;

    function automatic logic [SAMPLE_W-1:0] sample_pack(input sample_t s);
        return s;
    endfunction

    function automatic sample_t sample_unpack(input logic [SAMPLE_W-1:0] v);
        return sample_t'(v);
    endfunction

endpackage

// File: rtl/perceptron_sample_mem.sv
// DEPTH x 25-bit training-sample register file: one write port and one
// registered read port (write-first on a same-cycle address collision).
module perceptron_sample_mem
    import perceptron_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  sample_t       wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output sample_t       rd_data
);

    sample_t mem [DEPTH];

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
        end
    end

endmodule

// File: rtl/perceptron_trainer.sv
// Training-loop controller: streams stored samples to the neuron, counts
// misclassifications per epoch. Optional error log: PERCEPTRON_TRAINER_ERRLOG_EN.
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned AW          = $clog2(DEPTH),
    parameter int unsigned HOLD_CYCLES = 2,
    parameter logic [7:0]  MAX_EPOCHS  = DEFAULT_MAX_EPOCHS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [24:0]   wr_data,
    input  logic [AW:0]   num_samples,
    input  logic          start,
    input  logic          pred_in,
    output logic [7:0]    in1,
    output logic [7:0]    in2,
    output logic [7:0]    in3,
    output logic          desired_out,
    output logic          busy,
    output logic          done,
    output logic          converged,
    output logic [7:0]    epoch_count,
    output logic [AW:0]   err_count
`ifdef PERCEPTRON_TRAINER_ERRLOG_EN
    ,
    output logic [AW-1:0] first_err_addr,
    output logic          first_err_valid
`endif
);

    localparam int unsigned HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;

    trainer_state_t state, state_nx;

    logic [AW-1:0] addr;
    logic [HW-1:0] hold_cnt;
    logic [AW:0]   n_lat;
    sample_t       rd_q;

    logic          mem_we;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          accept_start;
    logic          last_hold;
    logic          last_sample;
    logic          mismatch;
    logic          epoch_restart;
    logic [7:0]    epoch_nx;

    perceptron_sample_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (mem_we),
        .wr_addr (wr_addr),
        .wr_data (sample_unpack(wr_data)),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_q)
    );

    assign in1         = rd_q.x1;
    assign in2         = rd_q.x2;
    assign in3         = rd_q.x3;
    assign desired_out = rd_q.desired;

    assign accept_start = (state == ST_IDLE) && start;
    assign last_hold    = (hold_cnt == HW'(HOLD_CYCLES - 1));
    assign last_sample  = ({1'b0, addr} == (n_lat - 1'b1));
    assign mismatch     = (state == ST_PRESENT) && last_hold && (pred_in != desired_out);
    assign epoch_nx     = (epoch_count == 8'hFF) ? epoch_count : epoch_count + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = (num_samples == '0) ? ST_FINISH : ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (last_hold && last_sample) begin
                    state_nx = ST_EPOCH_END;
                end
            end
            ST_EPOCH_END: begin
                if ((err_count == '0) || (epoch_nx == MAX_EPOCHS)) begin
                    state_nx = ST_FINISH;
                end else begin
                    state_nx = ST_PRESENT;
                end
            end
            ST_FINISH: state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // The read register is loaded on the edge that enters each sample, so the
    // features appear exactly when the hold window starts.
    always_comb begin
        mem_we        = 1'b0;
        rd_en         = 1'b0;
        rd_addr       = '0;
        epoch_restart = 1'b0;
        unique case (state)
            ST_IDLE: begin
                mem_we = wr_en && !reset;
                rd_en  = start && (num_samples != '0);
            end
            ST_PRESENT: begin
                rd_en   = last_hold && !last_sample;
                rd_addr = addr + 1'b1;
            end
            ST_EPOCH_END: begin
                epoch_restart = (state_nx == ST_PRESENT);
                rd_en         = epoch_restart;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr        <= '0;
            hold_cnt    <= '0;
            n_lat       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            converged   <= 1'b0;
            epoch_count <= '0;
            err_count   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        n_lat       <= num_samples;
                        addr        <= '0;
                        hold_cnt    <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        converged   <= 1'b0;
                        epoch_count <= '0;
                        err_count   <= '0;
                    end
                end
                ST_PRESENT: begin
                    if (last_hold) begin
                        hold_cnt <= '0;
                        if (mismatch && (err_count != (AW + 1)'(DEPTH))) begin
                            err_count <= err_count + 1'b1;
                        end
                        if (!last_sample) begin
                            addr <= addr + 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_EPOCH_END: begin
                    epoch_count <= epoch_nx;
                    if (err_count == '0) begin
                        converged <= 1'b1;
                    end else if (epoch_nx == MAX_EPOCHS) begin
                        converged <= 1'b0;
                    end else begin
                        err_count <= '0;
                        addr      <= '0;
                    end
                end
                ST_FINISH: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PERCEPTRON_TRAINER_ERRLOG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
        end else if (accept_start || epoch_restart) begin
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
        end else if (mismatch && !first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_addr  <= addr;
        end
    end
`endif

endmodule

// File: tb/tb_perceptron_trainer.sv
// Self-checking bench for perceptron_trainer: a time-offset reference model
// compared every cycle, plus directed literal checks and randomized runs.
module tb_perceptron_trainer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int H     = 2;
    localparam int MAXE  = 50;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [24:0]   wr_data;
    logic [AW:0]   num_samples;
    logic          start;
    logic          pred_in;
    logic [7:0]    in1, in2, in3;
    logic          desired_out, busy, done, converged;
    logic [7:0]    epoch_count;
    logic [AW:0]   err_count;
`ifdef PERCEPTRON_TRAINER_ERRLOG_EN
    logic [AW-1:0] first_err_addr;
    logic          first_err_valid;
`endif

    perceptron_trainer #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (H),
        .MAX_EPOCHS  (8'(MAXE))
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .num_samples (num_samples),
        .start       (start),
        .pred_in     (pred_in),
        .in1         (in1),
        .in2         (in2),
        .in3         (in3),
        .desired_out (desired_out),
        .busy        (busy),
        .done        (done),
        .converged   (converged),
        .epoch_count (epoch_count),
        .err_count   (err_count)
`ifdef PERCEPTRON_TRAINER_ERRLOG_EN
        ,
        .first_err_addr  (first_err_addr),
        .first_err_valid (first_err_valid)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mode   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: position inside a run is derived from the cycle count
    // since start (epoch length N*H+1), not from any FSM state.
    logic [24:0] m_mem [DEPTH];
    logic [24:0] m_in;
    bit          m_valid = 0, m_busy, m_done, m_conv, m_fin, m_fev;
    int          m_n, m_epoch, m_err, m_fea, t;

    initial for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    always @(posedge clk) begin
        int o, k;
        if (reset) begin
            m_valid = 1; m_busy = 0; m_done = 0; m_conv = 0; m_fin = 0;
            m_epoch = 0; m_err = 0; m_in = '0; m_fev = 0; m_fea = 0;
        end else if (!m_busy) begin
            if (wr_en) m_mem[wr_addr] = wr_data;
            if (start) begin
                m_n = int'(num_samples);
                m_busy = 1; m_done = 0; m_conv = 0; m_epoch = 0; m_err = 0;
                m_fev = 0; m_fea = 0; t = 0;
                m_fin = (m_n == 0);
                if (m_n != 0) m_in = m_mem[0];
            end
        end else if (m_fin) begin
            m_busy = 0; m_done = 1; m_fin = 0;
        end else begin
            t++;
            o = (t - 1) % (m_n * H + 1);
            if (o < m_n * H) begin
                k = o / H;
                if (o % H == H - 1) begin
                    if (pred_in != m_mem[k][24]) begin
                        if (m_err < DEPTH) m_err++;
                        if (!m_fev) begin m_fev = 1; m_fea = k; end
                    end
                    if (k + 1 < m_n) m_in = m_mem[k + 1];
                end
            end else begin
                if (m_epoch < 255) m_epoch++;
                if (m_err == 0) begin
                    m_conv = 1; m_fin = 1;
                end else if (m_epoch == MAXE) begin
                    m_fin = 1;
                end else begin
                    m_err = 0; m_in = m_mem[0]; m_fev = 0; m_fea = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("in1", in1, m_in[7:0]);
            chk("in2", in2, m_in[15:8]);
            chk("in3", in3, m_in[23:16]);
            chk("desired_out", desired_out, m_in[24]);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("epoch_count", epoch_count, m_epoch);
            chk("err_count", err_count, m_err);
            if (m_done) chk("converged", converged, m_conv);
`ifdef PERCEPTRON_TRAINER_ERRLOG_EN
            chk("first_err_valid", first_err_valid, m_fev);
            if (m_fev) chk("first_err_addr", first_err_addr, m_fea);
`endif
        end
    end

    // Neuron stand-in: 1 = always right, 2 = always wrong,
    // 3 = wrong only on samples tagged 2 and 5, otherwise mostly right.
    initial begin
        pred_in = 1'b0;
        forever begin
            @(negedge clk);
            case (mode)
                1:       pred_in = desired_out;
                2:       pred_in = ~desired_out;
                3:       pred_in = desired_out ^ ((in1 == 8'd2) || (in1 == 8'd5));
                default: pred_in = ($urandom_range(0, 19) == 0) ? ~desired_out : desired_out;
            endcase
        end
    end

    task automatic wr(input int a, input logic [24:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic run(input int n, input int m, input int budget, input bit junk,
                       output int cyc, output int in1_c1, output int in1_c3);
        mode = m; num_samples = (AW + 1)'(n); start = 1'b1;
        cyc = 0; in1_c1 = -1; in1_c3 = -1;
        do begin
            @(negedge clk);
            cyc++;
            start = 1'b0; wr_en = 1'b0;
            if (cyc == 1) in1_c1 = int'(in1);
            if (cyc == 3) in1_c3 = int'(in1);
            if (junk && busy && $urandom_range(0, 7) == 0) begin
                wr_en = 1'b1; wr_addr = 4'd1; wr_data = 25'h1AABBCC;
                start = 1'b1; num_samples = (AW + 1)'($urandom_range(0, DEPTH));
            end
        end while (!done && cyc < budget);
        start = 1'b0; wr_en = 1'b0;
        if (!done) chk("done_timeout", done, 1);
    endtask

    initial begin
        int cyc, c1, c3, guard;
        reset = 1'b1; wr_en = 1'b0; start = 1'b0; wr_addr = '0; wr_data = '0; num_samples = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_in1", in1, 0);
        chk("reset_epoch", epoch_count, 0);
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++)
            wr(i, {1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'(i)});

        // four samples, neuron always right
        run(4, 1, 100, 0, cyc, c1, c3);
        chk("n4_done_cycle", cyc, 11);
        chk("n4_in1_c1", c1, 0);
        chk("n4_in1_c3", c3, 1);
        chk("n4_epoch", epoch_count, 1);
        chk("n4_err", err_count, 0);
        chk("n4_conv", converged, 1);

        // three samples, neuron always wrong
        run(3, 2, 1000, 0, cyc, c1, c3);
        chk("n3_done_cycle", cyc, 352);
        chk("n3_epoch", epoch_count, 50);
        chk("n3_err", err_count, 3);
        chk("n3_conv", converged, 0);

        // empty training set
        run(0, 1, 20, 0, cyc, c1, c3);
        chk("n0_done_cycle", cyc, 2);
        chk("n0_epoch", epoch_count, 0);
        chk("n0_conv", converged, 0);
        chk("n0_in1_kept", in1, 2);

        // writes and starts while busy are dropped
        run(5, 0, 2000, 1, cyc, c1, c3);
        run(2, 1, 100, 0, cyc, c1, c3);
        chk("busy_wr_ignored", c3, 1);

        // same-cycle start and write to slot 0
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = {1'b1, 8'h11, 8'h22, 8'h77};
        run(2, 1, 100, 0, cyc, c1, c3);
        chk("start_wr_bypass", c1, 8'h77);

        // reset in epoch 2 at address 3
        mode = 2; num_samples = 5'd6; start = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            start = 1'b0; guard++;
        end while (!(epoch_count == 8'd2 && in1 == 8'd3) && guard < 500);
        chk("reach_epoch2_addr3", guard < 500, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_epoch", epoch_count, 0);
        chk("rst_mid_in1", in1, 0);
        reset = 1'b0;
        run(6, 1, 100, 0, cyc, c1, c3);
        chk("retrain_in1_c1", c1, 8'h77);
        chk("retrain_epoch", epoch_count, 1);

`ifdef PERCEPTRON_TRAINER_ERRLOG_EN
        run(8, 3, 2000, 0, cyc, c1, c3);
        chk("errlog_addr", first_err_addr, 2);
        chk("errlog_valid", first_err_valid, 1);
        chk("errlog_epoch", epoch_count, 50);
        chk("errlog_err", err_count, 2);
`endif

        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < 3; j++)
                wr(int'($urandom_range(0, DEPTH - 1)), 25'($urandom));
            run(int'($urandom_range(1, DEPTH)), 0, 2000, 1, cyc, c1, c3);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
